// File: rtl/c4_game_controller.sv
// c4_game_controller
//   Connect Four sequencing controller. Turns raw buttons into cursor moves
//   and piece drops, owns the 7x6 board, finds the landing row, scans the
//   four line directions through the placed piece and alternates players.
//
//   Ports:
//     clk_25MHz                 single 25 MHz clock
//     rst_n                     asynchronous active-low reset
//     move_left/right, drop_piece  raw active-high buttons (asynchronous)
//     rd_col, rd_row, rd_cell   combinational board read port for the renderer
//                               (out-of-range column/row read as 0)
//     cursor_col                cursor column 0..6
//     cur_player                0 = P1, 1 = P2
//     game_state                00 PLAY, 01 WIN, 10 DRAW
//     winner                    winning player, meaningful in WIN only
//     busy                      high while a drop is being processed
//
//   Build option: define C4_DEBOUNCE_EN to put a DEBOUNCE_CYCLES stability
//   filter between each synchronizer and its edge detector.
module c4_game_controller #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic       clk_25MHz,
    input  logic       rst_n,
    input  logic       move_left,
    input  logic       move_right,
    input  logic       drop_piece,
    input  logic [2:0] rd_col,
    input  logic [2:0] rd_row,
    output logic [1:0] rd_cell,
    output logic [2:0] cursor_col,
    output logic       cur_player,
    output logic [1:0] game_state,
    output logic       winner,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_FIND, S_PLACE, S_CHECK, S_RESOLVE, S_OVER
    } state_t;

    typedef enum logic [1:0] {
        GS_PLAY = 2'b00,
        GS_WIN  = 2'b01,
        GS_DRAW = 2'b10
    } gstate_t;

    if (DEBOUNCE_CYCLES < 1) begin : g_param_check
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    // Button front end, bit order {drop, right, left}
    logic [2:0] sync1_q, sync2_q, prev_q, btn_lvl, pulse;

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= {drop_piece, move_right, move_left};
            sync2_q <= sync1_q;
            prev_q  <= btn_lvl;
        end
    end

`ifdef C4_DEBOUNCE_EN
    localparam int CntW = $clog2(DEBOUNCE_CYCLES + 1);

    for (genvar b = 0; b < 3; b++) begin : g_db
        logic [CntW-1:0] cnt_q;
        logic            lvl_q;

        always_ff @(posedge clk_25MHz or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
                lvl_q <= 1'b0;
            end else if (sync2_q[b] == lvl_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
                cnt_q <= '0;
                lvl_q <= sync2_q[b];
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

        assign btn_lvl[b] = lvl_q;
    end
`else
    assign btn_lvl = sync2_q;
`endif

    assign pulse = btn_lvl & ~prev_q;

    // Game state
    state_t     state_q, state_d;
    gstate_t    gs_q, gs_d;
    logic [1:0] board_q [0:6][0:5];
    logic [2:0] cursor_q, cursor_d;
    logic [2:0] col_q, col_d;
    logic [2:0] row_q, row_d;
    logic [1:0] dir_q, dir_d;
    logic [5:0] moves_q, moves_d;
    logic       player_q, player_d;
    logic       winner_q, winner_d;
    logic       win_q, win_d;
    logic       board_we, board_clr;
    logic [1:0] code;
    logic [2:0] line_cnt;
    int         dc, dr, c, r;
    logic       run;

    assign code = player_q ? 2'b10 : 2'b01;

    // Contiguous same-colour run through (col_q,row_q) along the current
    // direction, at most 3 cells each side, stopping at the board edge.
    always_comb begin
        dc = 1;
        dr = 0;
        c  = 0;
        r  = 0;
        unique case (dir_q)
            2'd0:    begin dc = 1; dr = 0;  end
            2'd1:    begin dc = 0; dr = 1;  end
            2'd2:    begin dc = 1; dr = 1;  end
            default: begin dc = 1; dr = -1; end
        endcase
        line_cnt = 3'd1;
        run = 1'b1;
        for (int unsigned i = 1; i <= 3; i++) begin
            c = int'(col_q) + int'(i) * dc;
            r = int'(row_q) + int'(i) * dr;
            if (run && c >= 0 && c <= 6 && r >= 0 && r <= 5) begin
                if (board_q[3'(c)][3'(r)] == code) line_cnt = line_cnt + 3'd1;
                else run = 1'b0;
            end else begin
                run = 1'b0;
            end
        end
        run = 1'b1;
        for (int unsigned i = 1; i <= 3; i++) begin
            c = int'(col_q) - int'(i) * dc;
            r = int'(row_q) - int'(i) * dr;
            if (run && c >= 0 && c <= 6 && r >= 0 && r <= 5) begin
                if (board_q[3'(c)][3'(r)] == code) line_cnt = line_cnt + 3'd1;
                else run = 1'b0;
            end else begin
                run = 1'b0;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gs_d      = gs_q;
        cursor_d  = cursor_q;
        col_d     = col_q;
        row_d     = row_q;
        dir_d     = dir_q;
        moves_d   = moves_q;
        player_d  = player_q;
        winner_d  = winner_q;
        win_d     = win_q;
        board_we  = 1'b0;
        board_clr = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (pulse[2]) begin
                    col_d   = cursor_q;
                    row_d   = '0;
                    state_d = S_FIND;
                end else if (pulse[0] && !pulse[1]) begin
                    if (cursor_q != 3'd0) cursor_d = cursor_q - 3'd1;
                end else if (pulse[1] && !pulse[0]) begin
                    if (cursor_q != 3'd6) cursor_d = cursor_q + 3'd1;
                end
            end
            // Row 6 means rows 0..5 were all occupied: one extra cycle to
            // return, so a full column spends 6 FIND cycles plus the return.
            S_FIND: begin
                if (row_q == 3'd6)                       state_d = S_IDLE;
                else if (board_q[col_q][row_q] == 2'b00) state_d = S_PLACE;
                else                                     row_d = row_q + 3'd1;
            end
            S_PLACE: begin
                board_we = 1'b1;
                moves_d  = moves_q + 6'd1;
                dir_d    = '0;
                state_d  = S_CHECK;
            end
            S_CHECK: begin
                if (line_cnt >= 3'd4) win_d = 1'b1;
                dir_d = dir_q + 2'd1;
                if (dir_q == 2'd3) state_d = S_RESOLVE;
            end
            S_RESOLVE: begin
                if (win_q) begin
                    gs_d     = GS_WIN;
                    winner_d = player_q;
                    state_d  = S_OVER;
                end else if (moves_q == 6'd42) begin
                    gs_d    = GS_DRAW;
                    state_d = S_OVER;
                end else begin
                    player_d = ~player_q;
                    state_d  = S_IDLE;
                end
            end
            S_OVER: begin
                if (pulse[2]) begin
                    board_clr = 1'b1;
                    moves_d   = '0;
                    win_d     = 1'b0;
                    cursor_d  = 3'd3;
                    player_d  = 1'b0;
                    gs_d      = GS_PLAY;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            gs_q     <= GS_PLAY;
            cursor_q <= 3'd3;
            col_q    <= '0;
            row_q    <= '0;
            dir_q    <= '0;
            moves_q  <= '0;
            player_q <= 1'b0;
            winner_q <= 1'b0;
            win_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            gs_q     <= gs_d;
            cursor_q <= cursor_d;
            col_q    <= col_d;
            row_q    <= row_d;
            dir_q    <= dir_d;
            moves_q  <= moves_d;
            player_q <= player_d;
            winner_q <= winner_d;
            win_q    <= win_d;
        end
    end

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            board_q <= '{default: '0};
        end else if (board_clr) begin
            board_q <= '{default: '0};
        end else if (board_we) begin
            board_q[col_q][row_q] <= code;
        end
    end

    logic [2:0] rd_c, rd_r;
    assign rd_c    = (rd_col > 3'd6) ? 3'd0 : rd_col;
    assign rd_r    = (rd_row > 3'd5) ? 3'd0 : rd_row;
    assign rd_cell = board_q[rd_c][rd_r];

    assign cursor_col = cursor_q;
    assign cur_player = player_q;
    assign game_state = gs_q;
    assign winner     = winner_q;
    assign busy       = (state_q == S_FIND) || (state_q == S_PLACE) ||
                        (state_q == S_CHECK) || (state_q == S_RESOLVE);

endmodule

// File: tb/tb_c4_game_controller.sv
// Testbench for c4_game_controller: directed scenarios plus random games,
// checked against a board-level reference model.
module tb_c4_game_controller;

    logic       clk_25MHz = 1'b0;
    logic       rst_n;
    logic       move_left, move_right, drop_piece;
    logic [2:0] rd_col, rd_row;
    logic [1:0] rd_cell;
    logic [2:0] cursor_col;
    logic       cur_player;
    logic [1:0] game_state;
    logic       winner;
    logic       busy;

    always #20 clk_25MHz = ~clk_25MHz;

    c4_game_controller #(.DEBOUNCE_CYCLES(4)) dut (
        .clk_25MHz (clk_25MHz),
        .rst_n     (rst_n),
        .move_left (move_left),
        .move_right(move_right),
        .drop_piece(drop_piece),
        .rd_col    (rd_col),
        .rd_row    (rd_row),
        .rd_cell   (rd_cell),
        .cursor_col(cursor_col),
        .cur_player(cur_player),
        .game_state(game_state),
        .winner    (winner),
        .busy      (busy)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: cell codes 0 empty, 1 P1, 2 P2
    int mb [7][6];
    int m_cursor, m_player, m_gs, m_winner, m_moves;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int col_height(input int col);
        int h = 0;
        for (int r = 0; r < 6; r++) if (mb[col][r] != 0) h = r + 1;
        return h;
    endfunction

    function automatic bit has_four(input int p);
        int dcol, drow, cc, rr;
        bit ok;
        for (int c = 0; c < 7; c++) begin
            for (int r = 0; r < 6; r++) begin
                for (int d = 0; d < 4; d++) begin
                    case (d)
                        0: begin dcol = 1; drow = 0; end
                        1: begin dcol = 0; drow = 1; end
                        2: begin dcol = 1; drow = 1; end
                        default: begin dcol = 1; drow = -1; end
                    endcase
                    ok = 1'b1;
                    for (int i = 0; i < 4; i++) begin
                        cc = c + i * dcol;
                        rr = r + i * drow;
                        if (cc < 0 || cc > 6 || rr < 0 || rr > 5) ok = 1'b0;
                        else if (mb[cc][rr] != p) ok = 1'b0;
                    end
                    if (ok) return 1'b1;
                end
            end
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 7; c++) for (int r = 0; r < 6; r++) mb[c][r] = 0;
        m_cursor = 3;
        m_player = 0;
        m_gs     = 0;
        m_winner = 0;
        m_moves  = 0;
    endtask

    task automatic check_status(input string tag);
        check_eq({tag, "_cursor"}, cursor_col, m_cursor);
        check_eq({tag, "_player"}, cur_player, m_player);
        check_eq({tag, "_state"}, game_state, m_gs);
        check_eq({tag, "_busy"}, busy, 0);
        if (m_gs == 1) check_eq({tag, "_winner"}, winner, m_winner);
    endtask

    task automatic check_board(input string tag);
        int r6, c6;
        for (int c = 0; c < 7; c++) begin
            for (int r = 0; r < 6; r++) begin
                rd_col = 3'(c);
                rd_row = 3'(r);
                #1;
                check_eq({tag, "_cell"}, rd_cell, mb[c][r]);
            end
        end
        // Out-of-range read addresses alias to column 0 / row 0
        r6 = $urandom_range(0, 5);
        rd_col = 3'd7;
        rd_row = 3'(r6);
        #1;
        check_eq({tag, "_col7"}, rd_cell, mb[0][r6]);
        c6 = $urandom_range(0, 6);
        rd_col = 3'(c6);
        rd_row = 3'($urandom_range(6, 7));
        #1;
        check_eq({tag, "_row67"}, rd_cell, mb[c6][0]);
    endtask

    task automatic do_reset();
        @(negedge clk_25MHz);
        rst_n = 1'b0;
        move_left = 1'b0; move_right = 1'b0; drop_piece = 1'b0;
        repeat (2) @(negedge clk_25MHz);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk_25MHz);
    endtask

    task automatic press(input bit l, input bit r, input bit d);
        @(negedge clk_25MHz);
        move_left = l; move_right = r; drop_piece = d;
        @(negedge clk_25MHz);
        move_left = 1'b0; move_right = 1'b0; drop_piece = 1'b0;
        repeat (4) @(negedge clk_25MHz);
    endtask

    task automatic move_cursor_to(input int t);
        int g = 0;
        while (m_cursor != t && g < 10) begin
            if (m_cursor < t) begin press(0, 1, 0); m_cursor++; end
            else              begin press(1, 0, 0); m_cursor--; end
            check_eq("cursor_step", cursor_col, m_cursor);
            g++;
        end
    endtask

    // co: 0 plain drop, 1 with coincident left, 2 with coincident right
    task automatic do_drop(input int co, input bit spurious);
        int n, m, k, col;
        bit full;
        col  = m_cursor;
        k    = col_height(col);
        full = (k == 6);
        @(negedge clk_25MHz);
        drop_piece = 1'b1;
        move_left  = (co == 1);
        move_right = (co == 2);
        n = 0;
        while (!busy && n < 10) begin @(negedge clk_25MHz); n++; end
        check_eq("drop_to_busy", n, 3);
        drop_piece = 1'b0; move_left = 1'b0; move_right = 1'b0;
        m = 0;
        while (busy && m < 40) begin
            @(negedge clk_25MHz);
            m++;
            if (spurious && m == 1) move_right = 1'b1;
            if (m == 3) move_right = 1'b0;
        end
        check_eq("busy_cycles", m, full ? 7 : 7 + k);
        if (!full) begin
            mb[col][k] = m_player + 1;
            m_moves++;
            if (has_four(m_player + 1)) begin
                m_gs = 1;
                m_winner = m_player;
            end else if (m_moves == 42) begin
                m_gs = 2;
            end else begin
                m_player = 1 - m_player;
            end
        end
        check_status("drop");
        check_board("drop");
    endtask

    task automatic play(input int col);
        move_cursor_to(col);
        do_drop(0, 1'b0);
    endtask

    task automatic over_sequence();
        press(0, 1, 0);
        check_eq("over_right_ignored", cursor_col, m_cursor);
        press(1, 0, 0);
        check_eq("over_left_ignored", cursor_col, m_cursor);
        check_eq("over_state_held", game_state, m_gs);
        press(0, 0, 1);
        model_reset();
        check_status("new_game");
        check_board("new_game");
    endtask

    task automatic random_game();
        int g = 0;
        while (m_gs == 0 && g < 120) begin
            move_cursor_to($urandom_range(0, 6));
            if ($urandom_range(0, 7) == 0) begin
                press(1, 1, 0);
                check_eq("both_ignored", cursor_col, m_cursor);
            end
            do_drop($urandom_range(0, 2), 1'($urandom_range(0, 1)));
            g++;
        end
        if (m_gs != 0) over_sequence();
        else do_reset();
    endtask

    initial begin
        repeat (90000) @(posedge clk_25MHz);
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        move_left = 1'b0; move_right = 1'b0; drop_piece = 1'b0;
        rd_col = '0; rd_row = '0;
        repeat (3) @(negedge clk_25MHz);
        rst_n = 1'b1;
        model_reset();
        check_status("reset");
        check_eq("reset_winner", winner, 0);
        check_board("reset");

        // Pulse latency and cursor update edge
        @(negedge clk_25MHz);
        move_right = 1'b1;
        @(negedge clk_25MHz);
        move_right = 1'b0;
        check_eq("lat_edge1", cursor_col, 3);
        @(negedge clk_25MHz);
        check_eq("lat_edge2", cursor_col, 3);
        @(negedge clk_25MHz);
        check_eq("lat_edge3", cursor_col, 4);
        repeat (3) @(negedge clk_25MHz);
        m_cursor = 4;
        for (int i = 0; i < 3; i++) begin
            press(0, 1, 0);
            m_cursor = (m_cursor < 6) ? m_cursor + 1 : 6;
            check_eq("right_sat", cursor_col, m_cursor);
        end
        for (int i = 0; i < 7; i++) begin
            press(1, 0, 0);
            m_cursor = (m_cursor > 0) ? m_cursor - 1 : 0;
            check_eq("left_sat", cursor_col, m_cursor);
        end
        press(1, 1, 0);
        check_eq("lr_same_cycle", cursor_col, 0);

        // First drop lands at the bottom of column 3
        do_reset();
        play(3);
        rd_col = 3'd3; rd_row = 3'd0; #1;
        check_eq("first_drop_cell", rd_cell, 1);
        check_eq("first_drop_player", cur_player, 1);

        // Fill column 0, then a drop into the full column
        do_reset();
        for (int i = 0; i < 7; i++) play(0);
        check_eq("full_col_player", cur_player, 0);

        // Horizontal win for P1
        do_reset();
        play(0); play(6); play(1); play(6); play(2); play(6); play(3);
        check_eq("hwin_state", game_state, 1);
        check_eq("hwin_winner", winner, 0);
        over_sequence();

        // Diagonal / win for P2
        do_reset();
        play(1); play(1); play(2); play(0); play(2);
        play(2); play(3); play(3); play(3); play(3);
        check_eq("dwin_state", game_state, 1);
        check_eq("dwin_winner", winner, 1);
        over_sequence();

        // 42-move fill without a line: column colours AABBAAB
        do_reset();
        for (int p = 0; p < 3; p++) begin
            for (int j = 0; j < 3; j++) begin
                int a, b;
                a = (p == 0) ? 0 : (p == 1) ? 1 : 4;
                b = (p == 0) ? 2 : (p == 1) ? 3 : 6;
                play(a); play(b); play(b); play(a);
            end
        end
        for (int i = 0; i < 6; i++) play(5);
        check_eq("draw_state", game_state, 2);
        over_sequence();

        // Drop and right press in the same cycle
        do_reset();
        move_cursor_to(2);
        do_drop(2, 1'b0);
        check_eq("drop_move_cursor", cursor_col, 2);
        rd_col = 3'd2; rd_row = 3'd0; #1;
        check_eq("drop_move_cell", rd_cell, 1);

        // Reset asserted while the drop is in CHECK
        do_reset();
        @(negedge clk_25MHz);
        drop_piece = 1'b1;
        n = 0;
        while (!busy && n < 10) begin @(negedge clk_25MHz); n++; end
        check_eq("midreset_busy_seen", n, 3);
        drop_piece = 1'b0;
        repeat (2) @(negedge clk_25MHz);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_status("midreset");
        check_eq("midreset_winner", winner, 0);
        rd_col = 3'd3; rd_row = 3'd0; #1;
        check_eq("midreset_cell", rd_cell, 0);
        @(negedge clk_25MHz);
        rst_n = 1'b1;
        @(negedge clk_25MHz);
        check_board("after_midreset");

        // Random games
        for (int gm = 0; gm < 3; gm++) begin
            do_reset();
            random_game();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
